// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming(16,11) definitions used by both ends of the link.
// Holds codeword/data widths, the data-position table, the decoded output
// layout and a data-extraction helper so encoder and decoder cannot diverge.
package hamming_pkg;

    localparam int unsigned CW_W      = 16;
    localparam int unsigned DATA_W    = 11;
    localparam int unsigned SYN_W     = 4;
    localparam int unsigned FLAG_CORR = 11;
    localparam int unsigned FLAG_DBL  = 12;

    // Codeword position of data bit d[k], k = 0..10, packed 4 bits per entry (d[0] in the LSBs)
    localparam logic [DATA_W*4-1:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    // Decoder verdict for one codeword
    typedef enum logic [1:0] {
        DEC_CLEAN  = 2'd0,
        DEC_SINGLE = 2'd1,
        DEC_DOUBLE = 2'd2
    } dec_class_e;

    // Decoded output word; flag bit positions line up with FLAG_CORR / FLAG_DBL
    typedef struct packed {
        logic [2:0]        rsvd;
        logic              dbl_err;
        logic              corrected;
        logic [DATA_W-1:0] data;
    } rcv_out_t;

    // Pull the 11 data bits out of a codeword (mirrors DATA_POS)
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[15], cw[14], cw[13], cw[12], cw[11], cw[10],
                cw[9],  cw[7],  cw[6],  cw[5],  cw[3]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for a Hamming(16,11) codeword.
// Ports:
//   cw     in   16  codeword
//   syn_c  out  4   XOR of the indices i (1..15) where cw[i] = 1
//   par_c  out  1   XOR of all 16 codeword bits
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [SYN_W-1:0] syn_c,
    output logic             par_c
);

    // Syndrome bit b covers every position whose index has bit b set
    localparam logic [CW_W-1:0] MASK0 = 16'hAAAA;
    localparam logic [CW_W-1:0] MASK1 = 16'hCCCC;
    localparam logic [CW_W-1:0] MASK2 = 16'hF0F0;
    localparam logic [CW_W-1:0] MASK3 = 16'hFF00;

    always_comb begin
        syn_c    = '0;
        syn_c[0] = ^(cw & MASK0);
        syn_c[1] = ^(cw & MASK1);
        syn_c[2] = ^(cw & MASK2);
        syn_c[3] = ^(cw & MASK3);
        par_c    = ^cw;
    end

endmodule

// File: rtl/receiver.sv
// SECDED Hamming(16,11) decoder: accepts one codeword every clock, corrects
// single-bit errors, flags double-bit errors and emits data plus status.
// Parameters:
//   PIPE_IN    1 = register symb_in before decoding (latency 2), 0 = latency 1
// Configuration macro:
//   RCV_CORRECTION_EN  defined   -> single errors are corrected
//                      undefined -> detect-only: raw data, out[11] still flags it
// Ports:
//   symb_in     in   16  codeword, sampled every clock
//   out         out  16  {3'b0, dbl_err, corrected, data[10:0]} (registered)
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous active-low reset
//   read_ready  out  1   high while out holds a decoded codeword (registered)
module receiver
    import hamming_pkg::*;
#(
    parameter int unsigned PIPE_IN = 1
) (
    input  logic [CW_W-1:0] symb_in,
    output logic [CW_W-1:0] out,
    input  logic            clk,
    input  logic            reset,
    output logic            read_ready
);

    localparam int unsigned VLD_D = 1 + PIPE_IN;

    logic [CW_W-1:0]  cw;
    logic [SYN_W-1:0] syn;
    logic             par;
    logic [VLD_D-1:0] vld;
    dec_class_e       dec_class;
    rcv_out_t         dec_word;

    // Optional input register
    generate
        if (PIPE_IN != 0) begin : g_pipe_in
            logic [CW_W-1:0] cw_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cw_q <= '0;
                end else begin
                    cw_q <= symb_in;
                end
            end

            assign cw = cw_q;
        end else begin : g_no_pipe_in
            assign cw = symb_in;
        end
    endgenerate

    hamming_syndrome u_syndrome (
        .cw    (cw),
        .syn_c (syn),
        .par_c (par)
    );

    // Classify: odd overall parity means exactly one flip (syndrome 0 -> bit 0)
    always_comb begin
        dec_class = DEC_CLEAN;
        if (par) begin
            dec_class = DEC_SINGLE;
        end else if (syn != '0) begin
            dec_class = DEC_DOUBLE;
        end
    end

    // Extract data, with the flagged bit repaired when correction is built in
    always_comb begin
        dec_word           = '0;
        dec_word.data      = extract_data(cw);
        dec_word.corrected = 1'b0;
        dec_word.dbl_err   = 1'b0;
        case (dec_class)
            DEC_SINGLE: begin
`ifdef RCV_CORRECTION_EN
                dec_word.data = extract_data(cw ^ (CW_W'(1) << syn));
`endif
                dec_word.corrected = 1'b1;
            end
            DEC_DOUBLE: begin
                dec_word.dbl_err = 1'b1;
            end
            default: begin
                dec_word.corrected = 1'b0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else begin
            out <= dec_word;
        end
    end

    // Valid shift register: fills with ones after reset, read_ready is its tail
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld <= VLD_D'({vld, 1'b1});
        end
    end

    assign read_ready = vld[VLD_D-1];

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver (PIPE_IN = 1). Stimulus pushes the expected
// decoded word per codeword; a negedge monitor pops and compares.
module tb_receiver;

    logic        clk;
    logic        reset;
    logic [15:0] symb_in;
    logic [15:0] out;
    logic        read_ready;

    receiver #(.PIPE_IN(1)) dut (
        .symb_in    (symb_in),
        .out        (out),
        .clk        (clk),
        .reset      (reset),
        .read_ready (read_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          edge_cnt = 0;
    bit          stop_mon = 1'b0;
    int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

`ifdef RCV_CORRECTION_EN
    localparam bit CORR_EN = 1'b1;
`else
    localparam bit CORR_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c = '0;
        for (int k = 0; k < 11; k++) c[dpos[k]] = d[k];
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int i = 1; i < 16; i++) if (((i >> b) & 1) == 1) p ^= c[i];
            c[1 << b] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        for (int k = 0; k < 11; k++) d[k] = c[dpos[k]];
        return d;
    endfunction

    function automatic logic [15:0] mk(input logic dbl, input logic corr, input logic [10:0] d);
        return {3'b000, dbl, corr, d};
    endfunction

    // Edges seen since reset release; read_ready is due from the 2nd one
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else if (edge_cnt < 2) edge_cnt <= edge_cnt + 1;
    end

    // Monitor
    always @(negedge clk) begin
        if (!stop_mon) begin
            if (!reset) begin
                check("reset_out", out, 16'h0000);
                check("reset_ready", 16'(read_ready), 16'h0000);
            end else begin
                check("read_ready", 16'(read_ready), 16'(edge_cnt >= 2));
                if (edge_cnt >= 2) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL scoreboard_empty: got out %h expected a queued entry", out);
                    end else begin
                        check("out", out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] cw, input logic [15:0] exp);
        @(posedge clk);
        #1;
        symb_in = cw;
        exp_q.push_back(exp);
    endtask

    task automatic release_rst(input logic [15:0] cw, input logic [15:0] exp);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        symb_in = cw;
        exp_q.push_back(exp);
    endtask

    task automatic send_single(input logic [10:0] v, input int pos);
        logic [15:0] c;
        c = encode(v) ^ (16'(1) << pos);
        send(c, mk(1'b0, 1'b1, CORR_EN ? v : extract(c)));
    endtask

    task automatic send_double(input logic [10:0] v, input int a, input int b);
        logic [15:0] c;
        c = encode(v) ^ (16'(1) << a) ^ (16'(1) << b);
        send(c, mk(1'b1, 1'b0, extract(c)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          vals [3];
        vals = '{0, 2047, 677};
        reset   = 1'b1;
        symb_in = 16'h000F;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Directed vectors
        release_rst(16'h0000, 16'h0000);
        send(16'h0000, 16'h0000);
        send(16'h000F, 16'h0001);
        send(16'h0007, CORR_EN ? 16'h0801 : 16'h0800);
        send(16'h0009, 16'h1001);
        send(16'h16A1, 16'h10BA);
        repeat (3) send(16'h000F, 16'h0001);

        // Asynchronous reset mid-stream
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_out", out, 16'h0000);
        check("async_reset_ready", 16'(read_ready), 16'h0000);
        repeat (2) @(posedge clk);
        release_rst(16'h000F, 16'h0001);
        send(16'h16A1, 16'h10BA);

        // Every data value: clean, one single flip, one double flip
        for (int v = 0; v < 2048; v++) send(encode(11'(v)), mk(1'b0, 1'b0, 11'(v)));
        for (int v = 0; v < 2048; v++) send_single(11'(v), v % 16);
        for (int v = 0; v < 2048; v++) send_double(11'(v), v % 16, ((v % 16) + ((v / 16) % 15) + 1) % 16);

        // Every single and double flip for a few data values
        foreach (vals[j]) begin
            for (int a = 0; a < 16; a++) send_single(11'(vals[j]), a);
            for (int a = 0; a < 16; a++)
                for (int b = a + 1; b < 16; b++) send_double(11'(vals[j]), a, b);
        end

        repeat (3) send(16'h0000, 16'h0000);
        @(posedge clk);
        #1 stop_mon = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
